// File: rtl/audioplay_keys_in_if.sv
// Avalon-MM slave register bus for the key input block.
// The master drives the request signals; the slave returns registered read data.
interface audioplay_keys_in_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport slave  (input address, chipselect, write_n, writedata, output readdata);
  modport master (output address, chipselect, write_n, writedata, input readdata);
endinterface

// File: rtl/audioplay_keys_in.sv
// Debounced key/switch input port with edge capture, interrupt mask and
// an Avalon-MM register interface (deb, zero, irqmask, edgecap).
module audioplay_keys_in #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter bit CAPTURE_FALLING = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  audioplay_keys_in_if.slave   bus,
  input  logic [WIDTH-1:0]     in_port,
  output logic                 irq
);

  localparam int               CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0] IDLE     = {WIDTH{CAPTURE_FALLING}};

  logic [WIDTH-1:0] r_sync_p0;
  logic [WIDTH-1:0] r_sync_p1;
  logic [WIDTH-1:0] r_deb;
  logic [CNT_W-1:0] r_cnt [WIDTH];
  logic [WIDTH-1:0] r_edgecap;
  logic [WIDTH-1:0] r_irqmask;
  logic [31:0]      r_readdata;

  logic [WIDTH-1:0] w_load;
  logic [WIDTH-1:0] w_deb_nxt;
  logic [WIDTH-1:0] w_set;
  logic [WIDTH-1:0] w_clr;
  logic [31:0]      w_rdata;
  logic             w_wr;
  logic             w_rd;

  assign w_wr = bus.chipselect && !bus.write_n;
  assign w_rd = bus.chipselect &&  bus.write_n;

  // Stage p0/p1: two-flop synchronizer for the asynchronous pins
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync_p0 <= IDLE;
      r_sync_p1 <= IDLE;
    end else begin
      r_sync_p0 <= in_port;
      r_sync_p1 <= r_sync_p0;
    end
  end

  // Stage p2: per-bit debounce; a level is accepted after the count expires
  always_comb begin
    w_load    = '0;
    w_deb_nxt = r_deb;
    w_set     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_load[i] = (r_sync_p1[i] != r_deb[i]) && (r_cnt[i] == CNT_LAST);
      if (w_load[i]) begin
        w_deb_nxt[i] = r_sync_p1[i];
        w_set[i]     = CAPTURE_FALLING ? ~r_sync_p1[i] : r_sync_p1[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_deb <= IDLE;
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
    end else begin
      r_deb <= w_deb_nxt;
      for (int i = 0; i < WIDTH; i++) begin
        if ((r_sync_p1[i] == r_deb[i]) || w_load[i]) r_cnt[i] <= '0;
        else                                         r_cnt[i] <= r_cnt[i] + CNT_W'(1);
      end
    end
  end

  // A capture on the same edge as a write-1-to-clear keeps the bit set
  assign w_clr = (w_wr && (bus.address == 2'd3)) ? bus.writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_edgecap <= '0;
      r_irqmask <= '0;
    end else begin
      r_edgecap <= (r_edgecap & ~w_clr) | w_set;
      if (w_wr && (bus.address == 2'd2)) r_irqmask <= bus.writedata[WIDTH-1:0];
    end
  end

  always_comb begin
    w_rdata = '0;
    case (bus.address)
      2'd0:    w_rdata[WIDTH-1:0] = r_deb;
      2'd2:    w_rdata[WIDTH-1:0] = r_irqmask;
      2'd3:    w_rdata[WIDTH-1:0] = r_edgecap;
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)     r_readdata <= '0;
    else if (w_rd) r_readdata <= w_rdata;
  end

  assign bus.readdata = r_readdata;
  assign irq          = |(r_edgecap & r_irqmask);

  if (WIDTH < 32) begin : g_unused
    logic w_unused_wdata;
    assign w_unused_wdata = ^bus.writedata[31:WIDTH];
  end

endmodule

// File: tb/tb_audioplay_keys_in.sv
// Directed bench for audioplay_keys_in (WIDTH=4, DEBOUNCE_CYCLES=4, falling capture):
// register-map vector table plus hand-written debounce/capture/reset sequences.
module tb_audioplay_keys_in;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] in_port = 4'hF;
  logic       irq;
  int         total = 0;
  int         bad = 0;
  logic [31:0] rd;

  audioplay_keys_in_if bus();

  audioplay_keys_in #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .CAPTURE_FALLING(1'b1)) dut (
    .clk(clk), .reset(reset), .bus(bus), .in_port(in_port), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [1:0]  a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t tbl [11];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
    bus.chipselect = 1'b1; bus.write_n = 1'b1; bus.address = a;
    tick();
    bus.chipselect = 1'b0;
    d = bus.readdata;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] wd);
    bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.address = a; bus.writedata = wd;
    tick();
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic rd_chk(input string nm, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_rd(a, d);
    chk(nm, d, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.address = 2'd0; bus.writedata = '0;

    tbl[0]  = '{1'b1, 2'd2, 32'hFFFF_FFF1, 32'h1, 1'b1};
    tbl[1]  = '{1'b0, 2'd2, 32'h0,         32'h1, 1'b1};
    tbl[2]  = '{1'b0, 2'd1, 32'h0,         32'h0, 1'b1};
    tbl[3]  = '{1'b1, 2'd0, 32'h0,         32'h0, 1'b1};
    tbl[4]  = '{1'b0, 2'd0, 32'h0,         32'hE, 1'b1};
    tbl[5]  = '{1'b1, 2'd1, 32'hF,         32'hE, 1'b1};
    tbl[6]  = '{1'b0, 2'd1, 32'h0,         32'h0, 1'b1};
    tbl[7]  = '{1'b0, 2'd3, 32'h0,         32'h1, 1'b1};
    tbl[8]  = '{1'b1, 2'd3, 32'h1,         32'h1, 1'b0};
    tbl[9]  = '{1'b0, 2'd3, 32'h0,         32'h0, 1'b0};
    tbl[10] = '{1'b0, 2'd2, 32'h0,         32'h1, 1'b0};

    // Reset with keys idle
    tick(); tick(); tick();
    reset = 1'b0;
    chk("rst_readdata", bus.readdata, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    rd_chk("rst_deb", 2'd0, 32'hF);
    rd_chk("rst_edgecap", 2'd3, 32'h0);
    rd_chk("rst_irqmask", 2'd2, 32'h0);

    // Basic capture with exact latency; read on the capture edge sees pre-edge value
    in_port[0] = 1'b0;
    repeat (5) tick();
    rd_chk("cap_edgecap_pre", 2'd3, 32'h0);
    rd_chk("cap_deb", 2'd0, 32'hE);
    rd_chk("cap_edgecap", 2'd3, 32'h1);
    chk("cap_irq_masked", {31'b0, irq}, 32'h0);

    // Register map, masking and clearing
    for (int i = 0; i < 11; i++) begin
      if (tbl[i].wr) bus_wr(tbl[i].a, tbl[i].wd);
      else           bus_rd(tbl[i].a, rd);
      chk($sformatf("vec%0d_readdata", i), bus.readdata, tbl[i].exp_rd);
      chk($sformatf("vec%0d_irq", i), {31'b0, irq}, {31'b0, tbl[i].exp_irq});
    end
    repeat (3) tick();
    chk("hold_readdata", bus.readdata, 32'h1);

    // Rising release is not captured
    in_port[0] = 1'b1;
    repeat (8) tick();
    rd_chk("rel_deb", 2'd0, 32'hF);
    rd_chk("rel_edgecap", 2'd3, 32'h0);
    chk("rel_irq", {31'b0, irq}, 32'h0);

    // Three-cycle glitch is rejected
    in_port[1] = 1'b0;
    repeat (3) tick();
    in_port[1] = 1'b1;
    repeat (6) tick();
    rd_chk("glitch_deb", 2'd0, 32'hF);
    rd_chk("glitch_edgecap", 2'd3, 32'h0);

    // Set wins over a same-edge write-1-to-clear
    in_port[2] = 1'b0;
    repeat (5) tick();
    bus_wr(2'd3, 32'h4);
    rd_chk("setwin_edgecap", 2'd3, 32'h4);
    chk("setwin_irq_masked", {31'b0, irq}, 32'h0);
    bus_wr(2'd2, 32'h4);
    chk("setwin_irq", {31'b0, irq}, 32'h1);
    in_port = 4'hF;
    repeat (8) tick();
    bus_wr(2'd3, 32'hF);
    chk("setwin_clr_irq", {31'b0, irq}, 32'h0);
    rd_chk("setwin_clr", 2'd3, 32'h0);

    // Simultaneous events on two bits
    in_port = 4'b0110;
    repeat (8) tick();
    rd_chk("multi_edgecap", 2'd3, 32'h9);
    rd_chk("multi_deb", 2'd0, 32'h6);
    in_port = 4'hF;
    repeat (8) tick();
    bus_wr(2'd3, 32'hF);
    rd_chk("multi_clr", 2'd3, 32'h0);
    rd_chk("multi_deb_idle", 2'd0, 32'hF);

    // Reset mid-debounce abandons the count
    in_port[3] = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_readdata", bus.readdata, 32'h0);
    repeat (3) tick();
    rd_chk("mid_rst_cap_m3", 2'd3, 32'h0);
    rd_chk("mid_rst_cap_m4", 2'd3, 32'h0);
    rd_chk("mid_rst_cap_m5", 2'd3, 32'h0);
    rd_chk("mid_rst_deb", 2'd0, 32'h7);
    rd_chk("mid_rst_edgecap", 2'd3, 32'h8);
    rd_chk("mid_rst_irqmask", 2'd2, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
